ysyx_23060184_hazard_ctrl: RTL and testbench
============================================

# ysyx_23060184_hazard_ctrl

Pipeline hazard controller for the five-stage (F/D/E/M/W) NPC core. It handles operand forwarding and load-use interlock, and generates branch-redirect flushes. It also controls variable-latency instruction-fetch and memory-access stalls through ready/valid handshakes. Saturating performance counters record stall and flush events. It sits beside the datapath and drives every pipeline register's stall/flush input, the E-stage forwarding muxes and the PC-select.

## Interface
Parameters:
- REG_LENGTH, 5: register index width; use 4 for RV32E.
- CNT_WIDTH, 32: width of each performance counter.
- FWD_LENGTH, 2: forwarding-select width (`FWDA_MUX_*` / `FWDB_MUX_*` encodings).

Ports. Reset is synchronous and active-high; one clock.
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- Rs1D, Rs2D  in  REG_LENGTH  D-stage sources
- Rs1E, Rs2E, RdE  in  REG_LENGTH  E-stage sources and destination
- RdM, RdW  in  REG_LENGTH  M and W destinations
- RegWriteE, RegWriteM, RegWriteW  in  1  stage writes a register
- MemReadE, MemReadM  in  1  stage holds a load
- MemAccessM  in  1  M holds a load or store
- PCSrcE  in  `PC_SRC_LENGTH`  E-stage next-PC select
- ifu_valid  in  1  F has a fetched instruction this cycle
- lsu_req_ready  in  1  LSU accepts request
- lsu_resp_valid  in  1  LSU returns load data or store ack
- lsu_req_valid  out  1  request for the M-stage access
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushW  out  1  bubble stage register
- ForwardAE, ForwardBE  out  FWD_LENGTH  operand source select
- Branch  out  1  redirect PC; the datapath takes the redirect only when StallF=0
- load_use_cnt, mem_stall_cnt, fetch_stall_cnt, flush_cnt  out  CNT_WIDTH  saturating event counters

## Operation
- Forwarding, operand A (B is identical using Rs2E):
  - Select ALURESULTM if RegWriteM & !MemReadM & Rs1E≠0 & Rs1E==RdM.
  - Else select RESULTW if RegWriteW & Rs1E≠0 & Rs1E==RdW.
  - Else select RD1E.
  - A load in M never forwards; the load-use interlock guarantees this case is not needed.
- Load-use: lu = MemReadE & RegWriteE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D). Action: StallF, StallD, FlushE.
- Branch taken: br = (PCSrcE ≠ `PC_SRC_PCPlus4`). Action: Branch=1, FlushD, FlushE. Flushes take effect only when E is not stalled.
- Memory FSM (M stage), states MEM_IDLE, MEM_REQ, MEM_RESP:
  - MEM_IDLE with MemAccessM: go to MEM_REQ. lsu_req_valid=1 combinationally in MEM_REQ and in the MEM_IDLE entry cycle.
  - MEM_REQ with lsu_req_ready: go to MEM_RESP.
  - MEM_RESP with lsu_resp_valid: go to MEM_IDLE. M is released that same cycle.
  - Ready and resp in the same cycle as the request: go straight to MEM_IDLE, with zero stall cycles.
  - While the access is incomplete: ms=1. Action: StallF, StallD, StallE, StallM, FlushW.
- Fetch wait: fs = !ifu_valid. Action: StallF, FlushD.
- Drop flag: drop is set when Branch is taken while fs=1, so the in-flight fetch is wrong-path.
  - The next ifu_valid is consumed with FlushD=1 and StallF=0.
  - drop then clears.
- Priority: ms > br > lu > fs.
  - ms holds everything, including a branch in E.
  - br overrides lu; the load-use pair is on the wrong path.
- Counters each increment by 1 per cycle of their condition and saturate at all-ones:
  - load_use_cnt: lu and not overridden.
  - mem_stall_cnt: ms.
  - fetch_stall_cnt: fs.
  - flush_cnt: Branch accepted.

## Timing
- Forwarding, Branch, Stall* and Flush* are combinational from inputs and registered state, with zero latency.
- While reset=1:
  - FSM goes to MEM_IDLE; drop=0; counters=0.
  - Outputs are forced: Stall*=0, FlushD=FlushE=FlushW=1, lsu_req_valid=0, Branch=0.
- First cycle after reset deasserts: normal evaluation.
- Load-use costs exactly 1 bubble cycle.
- A memory access costs N stall cycles, where N = cycles until lsu_resp_valid.
- Reset mid-access (MEM_REQ or MEM_RESP): return to MEM_IDLE and drop the outstanding response. The LSU is reset by the same signal.
- lsu_req_valid, once raised, stays high until lsu_req_ready (AXI-style). Its inputs are held by StallM.

## Structure
- The existing defines header owns REG_LENGTH, `FWDA_MUX_*`, `FWDB_MUX_*`, `PC_SRC_*`, plus the new MEM_IDLE/MEM_REQ/MEM_RESP state encodings.
- Sub-module ysyx_23060184_sat_counter #(CNT_WIDTH), instantiated four times. It increments on en, clears on reset and holds at the maximum value.

## Test plan
- Forward priority: RdM=RdW=Rs1E=5, both RegWrite=1, MemReadM=0 → ForwardAE=ALURESULTM. Set Rs1E=0 → RD1E.
- Load-use: lw x6 in E, add using x6 in D → one cycle with StallF=StallD=FlushE=1 and load_use_cnt=1. Next cycle forwards from W.
- Memory wait: ready after 2 cycles, resp after 3 more → StallM high for 5 cycles, mem_stall_cnt=5, then MEM_IDLE.
- Branch during fetch wait: PCSrcE taken with ifu_valid=0 → Branch=1, flush_cnt=1. The next ifu_valid is bubbled (FlushD=1); the one after passes.
- Branch during memory stall: branch waits in E until the response arrives, then Branch=1 with FlushD=FlushE=1 in the release cycle.
- Reset asserted in MEM_RESP → next cycle MEM_IDLE, lsu_req_valid=0, counters 0; set CNT_WIDTH=3 and force 9 load-use hazards → count holds at 7.

Source files
------------

// File: rtl/ysyx_23060184_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: PC select, forwarding selects,
// memory-access FSM states and performance-counter slots.
package ysyx_23060184_hazard_ctrl_pkg;

    localparam int PC_SRC_LENGTH = 2;
    localparam logic [PC_SRC_LENGTH-1:0] PC_SRC_PCPlus4 = 2'd0;

    localparam logic [1:0] FWDA_MUX_RD1E       = 2'd0;
    localparam logic [1:0] FWDA_MUX_RESULTW    = 2'd1;
    localparam logic [1:0] FWDA_MUX_ALURESULTM = 2'd2;
    localparam logic [1:0] FWDB_MUX_RD1E       = 2'd0;
    localparam logic [1:0] FWDB_MUX_RESULTW    = 2'd1;
    localparam logic [1:0] FWDB_MUX_ALURESULTM = 2'd2;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    localparam int CNT_LOAD_USE = 0;
    localparam int CNT_MEM      = 1;
    localparam int CNT_FETCH    = 2;
    localparam int CNT_FLUSH    = 3;
    localparam int CNT_NUM      = 4;

endpackage

// File: rtl/ysyx_23060184_hazard_ctrl_if.sv
// LSU request/response handshake between the hazard controller (master)
// and the load/store unit (slave).
interface ysyx_23060184_hazard_ctrl_if;
    logic lsu_req_valid;
    logic lsu_req_ready;
    logic lsu_resp_valid;

    modport master (
        output lsu_req_valid,
        input  lsu_req_ready,
        input  lsu_resp_valid
    );

    modport slave (
        input  lsu_req_valid,
        output lsu_req_ready,
        output lsu_resp_valid
    );
endinterface

// File: rtl/ysyx_23060184_sat_counter.sv
// Event counter that counts up on en_i and sticks at all-ones.
module ysyx_23060184_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ysyx_23060184_hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use interlock,
// branch flush, LSU/IFU wait stalls and saturating event counters.
module ysyx_23060184_hazard_ctrl
    import ysyx_23060184_hazard_ctrl_pkg::*;
#(
    parameter int REG_LENGTH = 5,
    parameter int CNT_WIDTH  = 32,
    parameter int FWD_LENGTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [REG_LENGTH-1:0]    Rs1D,
    input  logic [REG_LENGTH-1:0]    Rs2D,
    input  logic [REG_LENGTH-1:0]    Rs1E,
    input  logic [REG_LENGTH-1:0]    Rs2E,
    input  logic [REG_LENGTH-1:0]    RdE,
    input  logic [REG_LENGTH-1:0]    RdM,
    input  logic [REG_LENGTH-1:0]    RdW,
    input  logic                     RegWriteE,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic                     MemReadE,
    input  logic                     MemReadM,
    input  logic                     MemAccessM,
    input  logic [PC_SRC_LENGTH-1:0] PCSrcE,
    input  logic                     ifu_valid,
    ysyx_23060184_hazard_ctrl_if.master lsu,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     StallM,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic                     FlushW,
    output logic [FWD_LENGTH-1:0]    ForwardAE,
    output logic [FWD_LENGTH-1:0]    ForwardBE,
    output logic                     Branch,
    output logic [CNT_WIDTH-1:0]     load_use_cnt,
    output logic [CNT_WIDTH-1:0]     mem_stall_cnt,
    output logic [CNT_WIDTH-1:0]     fetch_stall_cnt,
    output logic [CNT_WIDTH-1:0]     flush_cnt
);

    mem_state_e state_q, state_d;
    logic       drop_q, drop_d;
    logic       lu, br, fs, ms;
    logic       req_valid;

    logic [REG_LENGTH-1:0] rs_e    [2];
    logic [FWD_LENGTH-1:0] fwd_sel [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    // A load in M is never a forwarding source; the interlock covers it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            localparam logic [1:0] SEL_M = (gi == 0) ? FWDA_MUX_ALURESULTM : FWDB_MUX_ALURESULTM;
            localparam logic [1:0] SEL_W = (gi == 0) ? FWDA_MUX_RESULTW    : FWDB_MUX_RESULTW;
            localparam logic [1:0] SEL_R = (gi == 0) ? FWDA_MUX_RD1E       : FWDB_MUX_RD1E;
            logic hit_m, hit_w;
            assign hit_m = RegWriteM && !MemReadM && (rs_e[gi] != '0) && (rs_e[gi] == RdM);
            assign hit_w = RegWriteW && (rs_e[gi] != '0) && (rs_e[gi] == RdW);
            assign fwd_sel[gi] = hit_m ? FWD_LENGTH'(SEL_M) :
                                 hit_w ? FWD_LENGTH'(SEL_W) : FWD_LENGTH'(SEL_R);
        end
    endgenerate

    assign ForwardAE = fwd_sel[0];
    assign ForwardBE = fwd_sel[1];

    assign lu = MemReadE && RegWriteE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign br = (PCSrcE != PC_SRC_PCPlus4);
    assign fs = !ifu_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MEM_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // M is released in the cycle the response arrives, so ms drops with resp.
    always_comb begin
        state_d   = state_q;
        ms        = 1'b0;
        req_valid = 1'b0;
        unique case (state_q)
            MEM_IDLE: begin
                if (MemAccessM) begin
                    req_valid = 1'b1;
                    ms        = !(lsu.lsu_req_ready && lsu.lsu_resp_valid);
                    if (lsu.lsu_req_ready && lsu.lsu_resp_valid) state_d = MEM_IDLE;
                    else if (lsu.lsu_req_ready)                  state_d = MEM_RESP;
                    else                                         state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                req_valid = 1'b1;
                ms        = !(lsu.lsu_req_ready && lsu.lsu_resp_valid);
                if (lsu.lsu_req_ready && lsu.lsu_resp_valid) state_d = MEM_IDLE;
                else if (lsu.lsu_req_ready)                  state_d = MEM_RESP;
            end
            MEM_RESP: begin
                ms = !lsu.lsu_resp_valid;
                if (lsu.lsu_resp_valid) state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    assign lsu.lsu_req_valid = req_valid && !reset;

    // Priority ms > br > lu > fs; a taken branch never stalls F so the redirect lands.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        Branch = 1'b0;
        drop_d = drop_q;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
            drop_d = 1'b0;
        end else if (ms) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (br) begin
            Branch = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            drop_d = fs;
        end else if (lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (fs) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end else if (drop_q) begin
            FlushD = 1'b1;
            drop_d = 1'b0;
        end
    end

    logic [CNT_NUM-1:0]   cnt_en;
    logic [CNT_WIDTH-1:0] cnt_val [CNT_NUM];

    assign cnt_en[CNT_LOAD_USE] = lu && !ms && !br;
    assign cnt_en[CNT_MEM]      = ms;
    assign cnt_en[CNT_FETCH]    = fs;
    assign cnt_en[CNT_FLUSH]    = Branch;

    generate
        for (genvar gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
            ysyx_23060184_sat_counter #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_cnt (
                .clk     (clock),
                .srst    (reset),
                .en_i    (cnt_en[gi]),
                .count_o (cnt_val[gi])
            );
        end
    endgenerate

    assign load_use_cnt    = cnt_val[CNT_LOAD_USE];
    assign mem_stall_cnt   = cnt_val[CNT_MEM];
    assign fetch_stall_cnt = cnt_val[CNT_FETCH];
    assign flush_cnt       = cnt_val[CNT_FLUSH];

endmodule

// File: tb/tb_ysyx_23060184_hazard_ctrl.sv
// Directed-vector bench for the hazard controller; a second instance with
// 3-bit counters exercises saturation.
module tb_ysyx_23060184_hazard_ctrl;
    import ysyx_23060184_hazard_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM, MemAccessM;
    logic [PC_SRC_LENGTH-1:0] PCSrcE;
    logic ifu_valid;

    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, Branch;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] load_use_cnt, mem_stall_cnt, fetch_stall_cnt, flush_cnt;

    logic s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW, s_Branch;
    logic [1:0] s_ForwardAE, s_ForwardBE;
    logic [2:0] s_load_use_cnt, s_mem_stall_cnt, s_fetch_stall_cnt, s_flush_cnt;

    logic [7:0] ctl;
    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, Branch};

    ysyx_23060184_hazard_ctrl_if lsu0 ();
    ysyx_23060184_hazard_ctrl_if lsu1 ();

    always #5 clock = ~clock;

    ysyx_23060184_hazard_ctrl dut (
        .clock(clock), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .MemReadM(MemReadM), .MemAccessM(MemAccessM),
        .PCSrcE(PCSrcE), .ifu_valid(ifu_valid), .lsu(lsu0.master),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .Branch(Branch),
        .load_use_cnt(load_use_cnt), .mem_stall_cnt(mem_stall_cnt),
        .fetch_stall_cnt(fetch_stall_cnt), .flush_cnt(flush_cnt)
    );

    ysyx_23060184_hazard_ctrl #(.CNT_WIDTH(3)) dut_small (
        .clock(clock), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .MemReadM(MemReadM), .MemAccessM(MemAccessM),
        .PCSrcE(PCSrcE), .ifu_valid(ifu_valid), .lsu(lsu1.master),
        .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
        .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushW(s_FlushW),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .Branch(s_Branch),
        .load_use_cnt(s_load_use_cnt), .mem_stall_cnt(s_mem_stall_cnt),
        .fetch_stall_cnt(s_fetch_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lsu(input logic rdy, input logic rsp);
        lsu0.lsu_req_ready  = rdy;
        lsu0.lsu_resp_valid = rsp;
        lsu1.lsu_req_ready  = rdy;
        lsu1.lsu_resp_valid = rsp;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemReadE = 1'b0; MemReadM = 1'b0; MemAccessM = 1'b0;
        PCSrcE = '0;
        ifu_valid = 1'b1;
        set_lsu(1'b0, 1'b0);
    endtask

    logic [5:0] rdy_tab  = 6'b000100;
    logic [5:0] resp_tab = 6'b100000;
    logic [5:0] req_tab  = 6'b000111;

    initial begin
        // reset forces outputs regardless of hazards on the inputs
        reset = 1'b1;
        clear_inputs();
        MemAccessM = 1'b1; PCSrcE = 2'd1; ifu_valid = 1'b0;
        tick(); tick();
        check_val("rst_ctl", ctl, 8'b0000_1110);
        check_val("rst_req", lsu0.lsu_req_valid, 0);
        check_val("rst_cnt", load_use_cnt | mem_stall_cnt | fetch_stall_cnt | flush_cnt, 0);
        reset = 1'b0;
        clear_inputs();
        #1 check_val("idle_ctl", ctl, 8'b0000_0000);
        tick();

        // forwarding priority
        Rs1E = 5; Rs2E = 7; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
        #1 check_val("fwdA_m", ForwardAE, 2);
        check_val("fwdB_none", ForwardBE, 0);
        MemReadM = 1;
        #1 check_val("fwdA_load_in_m", ForwardAE, 1);
        MemReadM = 0; Rs2E = 5;
        #1 check_val("fwdB_m", ForwardBE, 2);
        tick();
        Rs1E = 0; RdM = 0; RdW = 0;
        #1 check_val("fwdA_x0", ForwardAE, 0);
        RegWriteM = 0; Rs1E = 5; RdM = 5; RdW = 5;
        #1 check_val("fwdA_w", ForwardAE, 1);
        tick();
        clear_inputs();

        // load-use: one bubble, then forward from W
        MemReadE = 1; RegWriteE = 1; RdE = 6; Rs1D = 6; Rs2D = 3;
        #1 check_val("lu_ctl", ctl, 8'b1100_0100);
        tick();
        MemReadE = 0; RegWriteE = 0; RdE = 0; RdM = 6; RegWriteM = 1; MemReadM = 1;
        #1 check_val("lu_bubble_ctl", ctl, 8'b0000_0000);
        check_val("lu_cnt", load_use_cnt, 1);
        tick();
        RdM = 0; RegWriteM = 0; MemReadM = 0; RdW = 6; RegWriteW = 1; Rs1E = 6; Rs1D = 0; Rs2D = 0;
        #1 check_val("lu_fwd_w", ForwardAE, 1);
        tick();
        clear_inputs();

        // memory wait: ready after 2 cycles, resp 3 cycles later
        for (int i = 0; i < 6; i++) begin
            MemAccessM = 1'b1;
            set_lsu(rdy_tab[i], resp_tab[i]);
            #1;
            check_val($sformatf("mem_ctl%0d", i), ctl, (i < 5) ? 8'b1111_0010 : 8'b0000_0000);
            check_val($sformatf("mem_req%0d", i), lsu0.lsu_req_valid, req_tab[i]);
            tick();
        end
        // back in idle: a new access raises the request, zero-stall handshake
        MemAccessM = 1; set_lsu(1, 1);
        #1 check_val("mem0_ctl", ctl, 8'b0000_0000);
        check_val("mem0_req", lsu0.lsu_req_valid, 1);
        tick();
        clear_inputs();
        #1 check_val("mem_cnt5", mem_stall_cnt, 5);
        tick();

        // branch during fetch wait drops the in-flight fetch
        PCSrcE = 2'd1; ifu_valid = 0;
        #1 check_val("brfs_ctl", ctl, 8'b0000_1101);
        tick();
        PCSrcE = 2'd0; ifu_valid = 0;
        #1 check_val("drop_wait_ctl", ctl, 8'b1000_1000);
        check_val("flush_cnt1", flush_cnt, 1);
        tick();
        ifu_valid = 1;
        #1 check_val("drop_eat_ctl", ctl, 8'b0000_1000);
        check_val("fetch_cnt2", fetch_stall_cnt, 2);
        tick();
        #1 check_val("drop_done_ctl", ctl, 8'b0000_0000);
        tick();

        // branch overrides load-use
        MemReadE = 1; RegWriteE = 1; RdE = 6; Rs1D = 6; PCSrcE = 2'd2;
        #1 check_val("brlu_ctl", ctl, 8'b0000_1101);
        tick();
        clear_inputs();
        #1 check_val("brlu_lu_cnt", load_use_cnt, 1);
        check_val("brlu_flush_cnt", flush_cnt, 2);
        check_val("brlu_after_ctl", ctl, 8'b0000_0000);
        tick();

        // branch waits in E behind a memory stall
        MemAccessM = 1; PCSrcE = 2'd1;
        #1 check_val("brms_hold_ctl", ctl, 8'b1111_0010);
        tick();
        set_lsu(1, 1);
        #1 check_val("brms_rel_ctl", ctl, 8'b0000_1101);
        tick();
        clear_inputs();
        #1 check_val("brms_flush_cnt", flush_cnt, 3);
        check_val("brms_mem_cnt", mem_stall_cnt, 6);
        tick();

        // reset while waiting for the response
        MemAccessM = 1;
        tick();
        set_lsu(1, 0);
        tick();
        set_lsu(0, 0);
        #1 check_val("resp_req", lsu0.lsu_req_valid, 0);
        check_val("resp_ctl", ctl, 8'b1111_0010);
        reset = 1;
        tick();
        reset = 0; MemAccessM = 0;
        #1 check_val("rst_mid_cnt", load_use_cnt | mem_stall_cnt | fetch_stall_cnt | flush_cnt, 0);
        check_val("rst_mid_ctl", ctl, 8'b0000_0000);
        MemAccessM = 1; set_lsu(1, 1);
        #1 check_val("rst_mid_idle_req", lsu0.lsu_req_valid, 1);
        check_val("rst_mid_idle_ctl", ctl, 8'b0000_0000);
        tick();
        clear_inputs();

        // 9 load-use cycles: 3-bit counter saturates at 7
        MemReadE = 1; RegWriteE = 1; RdE = 6; Rs2D = 6;
        repeat (9) tick();
        clear_inputs();
        #1 check_val("lu_sat_small", s_load_use_cnt, 7);
        check_val("lu_cnt9", load_use_cnt, 9);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
